// File: rtl/tc140l_out_pkg.sv
// tc140l_out_uart shared types: transmitter states, line-ending bytes
// and the hex-digit encoder used by the ASCII build (TC140L_OUT_ASCII_EN).
package tc140l_out_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    if (n < 4'd10) begin
      return 8'h30 + {4'h0, n};
    end
    return 8'h37 + {4'h0, n};
  endfunction

endpackage

// File: rtl/tc140l_out_fifo.sv
// Word FIFO between the CPU OUT strobe and the UART transmitter.
// Pushes while full are dropped and latch a sticky overflow flag.
module tc140l_out_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     wr_valid_i,
  input  logic [15:0]              wr_data_i,
  input  logic                     rd_pop_i,
  output logic [15:0]              rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     overflow_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [15:0]   mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic          ovf_q;
  logic          full, empty, push, pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = wr_valid_i && !full;
  assign pop   = rd_pop_i && !empty;

  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop) rptr_q <= rptr_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
      // a full-time push is lost even if a pop frees a slot this cycle
      if (wr_valid_i && full) ovf_q <= 1'b1;
    end
  end

  assign rd_data_o  = mem_q[rptr_q];
  assign count_o    = count_q;
  assign full_o     = full;
  assign empty_o    = empty;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/tc140l_out_uart.sv
// tc140l OUT-port serializer: FIFO plus 8N1 transmitter.
// Define TC140L_OUT_ASCII_EN to send each word as "HHHH\r\n" instead of 2 raw bytes.
module tc140l_out_uart
  import tc140l_out_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [15:0]                   out_data,
  input  logic                          out_valid,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          fifo_full,
  output logic                          overflow
);

`ifdef TC140L_OUT_ASCII_EN
  localparam int CHARS = 6;
  localparam int IW    = 3;
`else
  localparam int CHARS = 2;
  localparam int IW    = 1;
`endif

  localparam logic [IW-1:0] IDX_LAST = IW'(CHARS - 1);
  localparam logic [15:0]   BIT_LAST = 16'(CLKS_PER_BIT - 1);

  tx_state_e     state_q, state_d;
  logic [15:0]   timer_q, timer_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [15:0]   word_q, word_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          tx_q, tx_d;
  logic          pop, empty;
  logic [15:0]   head;
  logic [7:0]    char_b;

  tc140l_out_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .wr_valid_i(out_valid),
    .wr_data_i (out_data),
    .rd_pop_i  (pop),
    .rd_data_o (head),
    .count_o   (fifo_count),
    .full_o    (fifo_full),
    .empty_o   (empty),
    .overflow_o(overflow)
  );

`ifdef TC140L_OUT_ASCII_EN
  always_comb begin
    char_b = LF;
    case (idx_q)
      3'd0:    char_b = nibble_to_ascii(word_q[15:12]);
      3'd1:    char_b = nibble_to_ascii(word_q[11:8]);
      3'd2:    char_b = nibble_to_ascii(word_q[7:4]);
      3'd3:    char_b = nibble_to_ascii(word_q[3:0]);
      3'd4:    char_b = CR;
      default: char_b = LF;
    endcase
  end
`else
  always_comb begin
    char_b = idx_q[0] ? word_q[7:0] : word_q[15:8];
  end
`endif

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    word_d  = word_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          word_d  = head;
          idx_d   = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        shift_d = char_b;
        timer_d = BIT_LAST;
        tx_d    = 1'b0;
        state_d = ST_START;
      end
      ST_START: begin
        if (timer_q == '0) begin
          timer_d = BIT_LAST;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = '0;
          state_d = ST_DATA;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (timer_q == '0) begin
          timer_d = BIT_LAST;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = ST_STOP;
          end else begin
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      ST_STOP: begin
        if (timer_q == '0) begin
          if (idx_q < IDX_LAST) begin
            idx_d   = idx_q + IW'(1);
            state_d = ST_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      word_q  <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tc140l_out_uart.sv
// Directed bench for tc140l_out_uart at CLKS_PER_BIT=4, FIFO_DEPTH=8.
// Works for both builds; expected bytes follow TC140L_OUT_ASCII_EN.
module tb_tc140l_out_uart;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
`ifdef TC140L_OUT_ASCII_EN
  localparam int CHARS = 6;
`else
  localparam int CHARS = 2;
`endif
  localparam int FRAME = 10 * CPB;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] out_data = '0;
  logic        out_valid = 1'b0;
  logic        tx, tx_busy, fifo_full, overflow;
  logic [3:0]  fifo_count;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  tc140l_out_uart #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .out_data  (out_data),
    .out_valid (out_valid),
    .tx        (tx),
    .tx_busy   (tx_busy),
    .fifo_count(fifo_count),
    .fifo_full (fifo_full),
    .overflow  (overflow)
  );

  // line receiver: samples mid-bit on falling clock edges
  int         rx_t = -1;
  logic [7:0] rx_sh = '0;
  logic [7:0] rx_q[$];
  int         rx_start[$];
  int         rx_ferr = 0;

  always @(negedge clock) begin
    if (!reset_n) begin
      rx_t <= -1;
    end else if (rx_t < 0) begin
      if (tx === 1'b0) begin
        rx_t <= 1;
        rx_start.push_back(cyc);
      end
    end else begin
      rx_t <= rx_t + 1;
      if (rx_t == 2 && tx !== 1'b0) rx_ferr <= rx_ferr + 1;
      if (rx_t >= 6 && rx_t <= 34 && (rx_t % 4) == 2)
        rx_sh <= {tx, rx_sh[7:1]};
      if (rx_t == 38) begin
        rx_q.push_back(rx_sh);
        if (tx !== 1'b1) rx_ferr <= rx_ferr + 1;
        rx_t <= -1;
      end
    end
  end

  function automatic logic [7:0] exp_byte(input logic [15:0] w, input int k);
    logic [3:0] n;
`ifdef TC140L_OUT_ASCII_EN
    if (k == 4) return 8'h0D;
    if (k == 5) return 8'h0A;
    n = w[15-4*k -: 4];
    if (n < 4'd10) return 8'h30 + 8'(n);
    return 8'h41 + 8'(n) - 8'd10;
`else
    n = '0;
    return (k == 0) ? w[15:8] : w[7:0] ^ {4'h0, n};
`endif
  endfunction

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (!tx_busy && fifo_count == 4'd0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    vectors++;
    if (tx !== 1'b1) begin
      errors++; $display("FAIL reset_tx: got %b expected 1", tx);
    end
    vectors++;
    if (tx_busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b expected 0", tx_busy);
    end
    vectors++;
    if (fifo_count !== 4'd0) begin
      errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count);
    end
    vectors++;
    if (fifo_full !== 1'b0) begin
      errors++; $display("FAIL reset_full: got %b expected 0", fifo_full);
    end
    vectors++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL reset_ovf: got %b expected 0", overflow);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_single(input logic [15:0] w);
    int c0;
    rx_q.delete();
    rx_start.delete();
    @(negedge clock);
    c0 = cyc;
    out_data = w;
    out_valid = 1'b1;
    @(negedge clock);
    out_valid = 1'b0;
    vectors++;
    if (fifo_count !== 4'd1) begin
      errors++; $display("FAIL single_count: got %0d expected 1", fifo_count);
    end
    @(negedge clock);
    vectors++;
    if (tx !== 1'b1 || tx_busy !== 1'b1) begin
      errors++; $display("FAIL single_load: got tx=%b busy=%b expected 1 1", tx, tx_busy);
    end
    @(negedge clock);
    vectors++;
    if (tx !== 1'b0) begin
      errors++; $display("FAIL single_fall: got %b expected 0", tx);
    end
    while (cyc < c0 + 1 + (FRAME + 1) * CHARS) @(negedge clock);
    vectors++;
    if (tx_busy !== 1'b1) begin
      errors++; $display("FAIL single_busy_last: got %b expected 1", tx_busy);
    end
    @(negedge clock);
    vectors++;
    if (tx_busy !== 1'b0) begin
      errors++; $display("FAIL single_busy_end: got %b expected 0", tx_busy);
    end
    vectors++;
    if (rx_q.size() != CHARS) begin
      errors++; $display("FAIL single_nbytes: got %0d expected %0d", rx_q.size(), CHARS);
    end else begin
      for (int k = 0; k < CHARS; k++) begin
        vectors++;
        if (rx_q[k] !== exp_byte(w, k)) begin
          errors++; $display("FAIL single_byte%0d: got %h expected %h", k, rx_q[k], exp_byte(w, k));
        end
      end
      vectors++;
      if (rx_start[0] != c0 + 3) begin
        errors++; $display("FAIL single_start: got %0d expected %0d", rx_start[0] - c0, 3);
      end
      for (int k = 1; k < CHARS; k++) begin
        vectors++;
        if (rx_start[k] - rx_start[k-1] != FRAME + 1) begin
          errors++; $display("FAIL single_gap%0d: got %0d expected %0d", k, rx_start[k] - rx_start[k-1], FRAME + 1);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] w[2];
    int peak;
    bit ok;
    w[0] = 16'hBEEF;
    w[1] = 16'h0001;
    peak = 0;
    rx_q.delete();
    rx_start.delete();
    @(negedge clock);
    out_data = w[0];
    out_valid = 1'b1;
    @(negedge clock);
    out_data = w[1];
    if (int'(fifo_count) > peak) peak = int'(fifo_count);
    @(negedge clock);
    out_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      if (!tx_busy && fifo_count == 4'd0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    vectors++;
    if (!ok) begin
      errors++; $display("FAIL b2b_timeout: got busy=%b expected idle", tx_busy);
    end
    vectors++;
    if (peak != 1) begin
      errors++; $display("FAIL b2b_peak: got %0d expected 1", peak);
    end
    vectors++;
    if (rx_q.size() != 2 * CHARS) begin
      errors++; $display("FAIL b2b_nbytes: got %0d expected %0d", rx_q.size(), 2 * CHARS);
    end else begin
      for (int k = 0; k < 2 * CHARS; k++) begin
        vectors++;
        if (rx_q[k] !== exp_byte(w[k / CHARS], k % CHARS)) begin
          errors++; $display("FAIL b2b_byte%0d: got %h expected %h", k, rx_q[k], exp_byte(w[k / CHARS], k % CHARS));
        end
      end
      vectors++;
      if (rx_start[CHARS] - rx_start[CHARS-1] != FRAME + 2) begin
        errors++; $display("FAIL b2b_word_gap: got %0d expected %0d", rx_start[CHARS] - rx_start[CHARS-1], FRAME + 2);
      end
    end
  endtask

  task automatic test_overflow;
    bit ok;
    rx_q.delete();
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (i == 9) begin
        vectors++;
        if (fifo_count !== 4'd8 || fifo_full !== 1'b1) begin
          errors++; $display("FAIL ovf_full: got count=%0d full=%b expected 8 1", fifo_count, fifo_full);
        end
        vectors++;
        if (overflow !== 1'b0) begin
          errors++; $display("FAIL ovf_early: got %b expected 0", overflow);
        end
      end
      out_data = 16'(i);
      out_valid = 1'b1;
    end
    @(negedge clock);
    out_valid = 1'b0;
    vectors++;
    if (overflow !== 1'b1 || fifo_count !== 4'd8) begin
      errors++; $display("FAIL ovf_set: got ovf=%b count=%0d expected 1 8", overflow, fifo_count);
    end
    wait_idle(5000, ok);
    vectors++;
    if (!ok) begin
      errors++; $display("FAIL ovf_timeout: got busy=%b expected idle", tx_busy);
    end
    vectors++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow);
    end
    vectors++;
    if (rx_q.size() != 9 * CHARS) begin
      errors++; $display("FAIL ovf_nbytes: got %0d expected %0d", rx_q.size(), 9 * CHARS);
    end else begin
      for (int k = 0; k < 9 * CHARS; k++) begin
        vectors++;
        if (rx_q[k] !== exp_byte(16'(k / CHARS), k % CHARS)) begin
          errors++; $display("FAIL ovf_byte%0d: got %h expected %h", k, rx_q[k], exp_byte(16'(k / CHARS), k % CHARS));
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    int c0, noisy;
    bit ok;
    rx_q.delete();
    @(negedge clock);
    c0 = cyc;
    out_data = 16'h1234;
    out_valid = 1'b1;
    @(negedge clock);
    out_data = 16'h5678;
    @(negedge clock);
    out_data = 16'h9ABC;
    @(negedge clock);
    out_valid = 1'b0;
    while (cyc < c0 + 3 + (FRAME + 1) + 12) @(negedge clock);
    reset_n = 1'b0;
    #1;
    vectors++;
    if (tx !== 1'b1 || tx_busy !== 1'b0) begin
      errors++; $display("FAIL mid_tx: got tx=%b busy=%b expected 1 0", tx, tx_busy);
    end
    vectors++;
    if (fifo_count !== 4'd0 || fifo_full !== 1'b0) begin
      errors++; $display("FAIL mid_fifo: got count=%0d full=%b expected 0 0", fifo_count, fifo_full);
    end
    vectors++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL mid_ovf: got %b expected 0", overflow);
    end
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    noisy = 0;
    repeat (400) begin
      @(negedge clock);
      if (tx !== 1'b1 || tx_busy !== 1'b0) noisy++;
    end
    vectors++;
    if (noisy != 0) begin
      errors++; $display("FAIL mid_quiet: got %0d active cycles expected 0", noisy);
    end
    vectors++;
    if (rx_q.size() != 1 || rx_q[0] !== exp_byte(16'h1234, 0)) begin
      errors++; $display("FAIL mid_partial: got %0d bytes expected 1 byte %h", rx_q.size(), exp_byte(16'h1234, 0));
    end
    rx_q.delete();
    @(negedge clock);
    out_data = 16'h0F0F;
    out_valid = 1'b1;
    @(negedge clock);
    out_valid = 1'b0;
    wait_idle(1000, ok);
    vectors++;
    if (!ok || rx_q.size() != CHARS) begin
      errors++; $display("FAIL mid_resume: got %0d bytes expected %0d", rx_q.size(), CHARS);
    end else begin
      for (int k = 0; k < CHARS; k++) begin
        vectors++;
        if (rx_q[k] !== exp_byte(16'h0F0F, k)) begin
          errors++; $display("FAIL mid_byte%0d: got %h expected %h", k, rx_q[k], exp_byte(16'h0F0F, k));
        end
      end
    end
  endtask

  task automatic test_wrap;
    bit ok;
    rx_q.delete();
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      out_data = 16'h0100 + 16'(i);
      out_valid = 1'b1;
      @(negedge clock);
      out_valid = 1'b0;
      repeat (298) @(negedge clock);
    end
    wait_idle(1000, ok);
    vectors++;
    if (!ok || overflow !== 1'b0) begin
      errors++; $display("FAIL wrap_state: got idle=%b ovf=%b expected 1 0", ok, overflow);
    end
    vectors++;
    if (rx_q.size() != 20 * CHARS) begin
      errors++; $display("FAIL wrap_nbytes: got %0d expected %0d", rx_q.size(), 20 * CHARS);
    end else begin
      for (int k = 0; k < 20 * CHARS; k++) begin
        vectors++;
        if (rx_q[k] !== exp_byte(16'h0100 + 16'(k / CHARS), k % CHARS)) begin
          errors++; $display("FAIL wrap_byte%0d: got %h expected %h", k, rx_q[k], exp_byte(16'h0100 + 16'(k / CHARS), k % CHARS));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single(16'h1A2F);
    test_single(16'h0005);
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_wrap();
    vectors++;
    if (rx_ferr != 0) begin
      errors++; $display("FAIL framing: got %0d bad start/stop bits expected 0", rx_ferr);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
